// File: rtl/serial_reg_responder.sv
// Host-command responder on the byte side of the UART: 'W' addr data / 'R' addr frames, one reply byte each.
// Optional partial-frame idle timeout is enabled by defining SERIAL_RESP_TIMEOUT_EN.
module serial_reg_responder #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned TX_HOLDOFF = (CLK_FREQ / BAUD) * 12
`ifdef SERIAL_RESP_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 10
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_dat,
    input  logic       rx_ready,
    output logic       rx_ready_rst,
    output logic [7:0] tx_dat,
    output logic       tx_txe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata
);

    localparam int unsigned    HO_W    = $clog2(TX_HOLDOFF) + 1;
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(TX_HOLDOFF - 1);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        ACCESS,
        CAPTURE,
        REPLY
    } state_t;

    state_t          state_q;
    logic            is_wr_q;
    logic [7:0]      addr_buf_q;
    logic            rx_ready_rst_q;
    logic [7:0]      tx_dat_q;
    logic            tx_txe_q;
    logic [7:0]      reg_addr_q;
    logic [7:0]      reg_wdata_q;
    logic            reg_we_q;
    logic            reg_re_q;
    logic [HO_W-1:0] holdoff_q;

    logic rx_phase;
    logic consume;
    logic waiting;
    logic timeout_hit;

    assign rx_phase = (state_q == IDLE) || (state_q == GET_ADDR) || (state_q == GET_DATA);
    assign waiting  = (state_q == GET_ADDR) || (state_q == GET_DATA);
    // rx_ready is still high in the cycle of our own ready_rst pulse, so it is ignored there.
    assign consume  = rx_phase && rx_ready && !rx_ready_rst_q;

`ifdef SERIAL_RESP_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] idle_q;

    assign timeout_hit = waiting && !consume && (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else if (!waiting || consume || timeout_hit) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + TO_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            is_wr_q        <= 1'b0;
            addr_buf_q     <= '0;
            rx_ready_rst_q <= 1'b0;
            tx_dat_q       <= '0;
            tx_txe_q       <= 1'b0;
            reg_addr_q     <= '0;
            reg_wdata_q    <= '0;
            reg_we_q       <= 1'b0;
            reg_re_q       <= 1'b0;
            holdoff_q      <= '0;
        end else begin
            rx_ready_rst_q <= consume;
            reg_we_q       <= 1'b0;
            reg_re_q       <= 1'b0;
            tx_txe_q       <= 1'b0;
            if (holdoff_q != '0) begin
                holdoff_q <= holdoff_q - HO_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (consume) begin
                        if ((rx_dat == CMD_WRITE) || (rx_dat == CMD_READ)) begin
                            is_wr_q <= (rx_dat == CMD_WRITE);
                            state_q <= GET_ADDR;
                        end else begin
                            tx_dat_q <= RSP_ERR;
                            state_q  <= REPLY;
                        end
                    end
                end
                GET_ADDR: begin
                    if (consume) begin
                        addr_buf_q <= rx_dat;
                        if (is_wr_q) begin
                            state_q <= GET_DATA;
                        end else begin
                            reg_addr_q <= rx_dat;
                            reg_re_q   <= 1'b1;
                            state_q    <= ACCESS;
                        end
                    end else if (timeout_hit) begin
                        state_q <= IDLE;
                    end
                end
                GET_DATA: begin
                    // Bus address/data only change on entry to ACCESS, so they hold between accesses.
                    if (consume) begin
                        reg_addr_q  <= addr_buf_q;
                        reg_wdata_q <= rx_dat;
                        reg_we_q    <= 1'b1;
                        state_q     <= ACCESS;
                    end else if (timeout_hit) begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    tx_dat_q <= is_wr_q ? RSP_OK : reg_rdata;
                    state_q  <= REPLY;
                end
                REPLY: begin
                    if (holdoff_q == '0) begin
                        tx_txe_q  <= 1'b1;
                        holdoff_q <= HO_LOAD;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_ready_rst = rx_ready_rst_q;
    assign tx_dat       = tx_dat_q;
    assign tx_txe       = tx_txe_q;
    assign reg_addr     = reg_addr_q;
    assign reg_wdata    = reg_wdata_q;
    assign reg_we       = reg_we_q;
    assign reg_re       = reg_re_q;

endmodule

// File: tb/tb_serial_reg_responder.sv
// Self-checking bench for serial_reg_responder: frame table plus reset, latency, holdoff and timeout sequences.
module tb_serial_reg_responder;

    localparam int unsigned HOLD = 40;
`ifdef SERIAL_RESP_TIMEOUT_EN
    localparam int unsigned TMO = 60;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] rx_dat;
    logic       rx_ready;
    logic       rx_ready_rst;
    logic [7:0] tx_dat;
    logic       tx_txe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    serial_reg_responder #(
        .TX_HOLDOFF(HOLD)
`ifdef SERIAL_RESP_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_dat      (rx_dat),
        .rx_ready    (rx_ready),
        .rx_ready_rst(rx_ready_rst),
        .tx_dat      (tx_dat),
        .tx_txe      (tx_txe),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_we      (reg_we),
        .reg_re      (reg_re),
        .reg_rdata   (reg_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: read data only valid in the cycle after reg_re.
    logic [7:0] mem [256];
    logic       re_dly;
    initial re_dly = 1'b0;
    always @(posedge clk) re_dly <= reg_re;
    assign reg_rdata = re_dly ? mem[reg_addr] : 8'hEE;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    int last_consume = 0;
    int last_txe = 0;
    int prev_txe = 0;

    typedef struct {
        int         kind;   // 0 write strobe, 1 read strobe, 2 transmit
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;
    ev_t exp_q[$];

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         nb;
        logic [7:0] rdata;
        logic       exp_we;
        logic       exp_re;
        logic [7:0] exp_tx;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual kind=%0d addr=%0h data=%0h required none", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == e.kind) begin
                if (kind != 2) chk("reg_addr", a, e.a);
                if (kind != 1) chk(kind == 0 ? "reg_wdata" : "tx_dat", d, e.d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_we && reg_re) begin
                checks++;
                errors++;
                $display("FAIL strobe_overlap actual we=1 re=1 required exclusive");
            end
            if (reg_we) check_ev(0, reg_addr, reg_wdata);
            if (reg_re) check_ev(1, reg_addr, 8'h00);
            if (tx_txe) begin
                check_ev(2, 8'h00, tx_dat);
                prev_txe = last_txe;
                last_txe = cyc;
            end
        end
    end

    // Serial-side model: present a byte and drop ready once the DUT acknowledges it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_dat   = b;
        rx_ready = 1'b1;
        while (rx_ready_rst !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL consume_timeout actual no ready_rst required ready_rst for %0h", b);
        end
        rx_ready     = 1'b0;
        last_consume = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL response_timeout actual pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rx_ready_rst"}, rx_ready_rst, 0);
        chk({tag, "_tx_dat"}, tx_dat, 0);
        chk({tag, "_tx_txe"}, tx_txe, 0);
        chk({tag, "_reg_addr"}, reg_addr, 0);
        chk({tag, "_reg_wdata"}, reg_wdata, 0);
        chk({tag, "_reg_we"}, reg_we, 0);
        chk({tag, "_reg_re"}, reg_re, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual still running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = '{8'h57, 8'h12, 8'hA5, 3, 8'h00, 1'b1, 1'b0, 8'h4B};
        vecs[1] = '{8'h52, 8'h12, 8'h00, 2, 8'h3C, 1'b0, 1'b1, 8'h3C};
        vecs[2] = '{8'h41, 8'h00, 8'h00, 1, 8'h00, 1'b0, 1'b0, 8'h3F};
        vecs[3] = '{8'h52, 8'h00, 8'h00, 2, 8'h77, 1'b0, 1'b1, 8'h77};
        vecs[4] = '{8'h57, 8'hFF, 8'h00, 3, 8'h00, 1'b1, 1'b0, 8'h4B};
        vecs[5] = '{8'h52, 8'hFF, 8'h00, 2, 8'h81, 1'b0, 1'b1, 8'h81};
        vecs[6] = '{8'h00, 8'h00, 8'h00, 1, 8'h00, 1'b0, 1'b0, 8'h3F};
        vecs[7] = '{8'h57, 8'h00, 8'hFF, 3, 8'h00, 1'b1, 1'b0, 8'h4B};
        vecs[8] = '{8'h4B, 8'h00, 8'h00, 1, 8'h00, 1'b0, 1'b0, 8'h3F};
        vecs[9] = '{8'h52, 8'h57, 8'h00, 2, 8'h00, 1'b0, 1'b1, 8'h00};
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

        rst      = 1'b1;
        rx_dat   = 8'h00;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            if (v.nb == 2) mem[v.b1] = v.rdata;
            if (v.exp_we) push(0, v.b1, v.b2);
            if (v.exp_re) push(1, v.b1, 8'h00);
            push(2, 8'h00, v.exp_tx);
            send_byte(v.b0);
            if (v.nb > 1) send_byte(v.b1);
            if (v.nb > 2) send_byte(v.b2);
            wait_idle();
        end

        // Back-to-back reads: the second reply must wait out the holdoff.
        mem[8'h10] = 8'h11;
        mem[8'h20] = 8'h22;
        push(1, 8'h10, 8'h00);
        push(2, 8'h00, 8'h11);
        push(1, 8'h20, 8'h00);
        push(2, 8'h00, 8'h22);
        send_byte(8'h52);
        send_byte(8'h10);
        send_byte(8'h52);
        send_byte(8'h20);
        wait_idle();
        chk("holdoff_spacing_ok", (last_txe - prev_txe) >= HOLD, 1);

        // Reset mid-frame and mid-holdoff: no strobe or reply may follow.
        send_byte(8'h57);
        send_byte(8'h12);
        #3;
        rst = 1'b1;
        #1;
        check_outputs_zero("midframe_reset");
        repeat (2) @(posedge clk);
        #4;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Holdoff was cleared by reset, so the reply follows the last byte by 3 cycles.
        mem[8'h33] = 8'hC3;
        push(1, 8'h33, 8'h00);
        push(2, 8'h00, 8'hC3);
        send_byte(8'h52);
        send_byte(8'h33);
        wait_idle();
        chk("latency_cycles", last_txe - last_consume, 3);

`ifdef SERIAL_RESP_TIMEOUT_EN
        repeat (HOLD) @(posedge clk);
        #1;
        send_byte(8'h57);
        repeat (TMO + 5) @(posedge clk);
        #1;
        mem[8'h05] = 8'h5E;
        push(1, 8'h05, 8'h00);
        push(2, 8'h00, 8'h5E);
        send_byte(8'h52);
        send_byte(8'h05);
        wait_idle();
`endif

        repeat (HOLD + 5) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
